// File: rtl/traffic_phase_ctrl.sv
// Traffic light phase sequencer: loads Timer intervals, waits for expiry, drives lamps.
// Optional pedestrian phase enabled by defining TRAFFIC_WALK_EN.
module traffic_phase_ctrl #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2,
  parameter logic [3:0] T_WALK = 4'd5
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       expired,
  input  logic       Sensor,
  input  logic       Walk_Request,
  output logic [3:0] Value,
  output logic       start_timer,
  output logic [2:0] Main_RYG,
  output logic [2:0] Side_RYG,
  output logic       Walk
);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    SIDE_GRN = 3'd2,
    SIDE_EXT = 3'd3,
`ifdef TRAFFIC_WALK_EN
    SIDE_YEL = 3'd4,
    PED_WALK = 3'd5
`else
    SIDE_YEL = 3'd4
`endif
  } state_t;

  state_t     state_q, state_d;
  logic       boot_q;
  logic       armed_q, armed_d;
  logic       go;
  logic       main_exit;
  logic       start_d;
  logic [3:0] value_d;
  logic [2:0] main_d, side_d;
  logic       walk_d;

`ifdef TRAFFIC_WALK_EN
  logic pend_q, pend_d;
  assign main_exit = Sensor | pend_q;
`else
  logic       unused_walk_req;
  logic [3:0] unused_t_walk;
  assign unused_walk_req = Walk_Request;
  assign unused_t_walk   = T_WALK;
  assign main_exit       = Sensor;
`endif

  // Next state and registered-output values; a start pulse accompanies every (re)entry.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    armed_d = 1'b1;
    value_d = Value;
    main_d  = Main_RYG;
    side_d  = Side_RYG;
    walk_d  = 1'b0;
    go      = boot_q;
    if (armed_q && expired) begin
      go = 1'b1;
      case (state_q)
        MAIN_GRN: state_d = main_exit ? MAIN_YEL : MAIN_GRN;
        MAIN_YEL: state_d = SIDE_GRN;
        SIDE_GRN: state_d = Sensor ? SIDE_EXT : SIDE_YEL;
        SIDE_EXT: state_d = SIDE_YEL;
`ifdef TRAFFIC_WALK_EN
        SIDE_YEL: state_d = pend_q ? PED_WALK : MAIN_GRN;
        PED_WALK: state_d = MAIN_GRN;
`else
        SIDE_YEL: state_d = MAIN_GRN;
`endif
        default:  state_d = MAIN_GRN;
      endcase
    end
    if (go) begin
      start_d = 1'b1;
      armed_d = 1'b0;
      case (state_d)
        MAIN_YEL: begin value_d = T_YEL;  main_d = LAMP_Y; side_d = LAMP_R; end
        SIDE_GRN: begin value_d = T_BASE; main_d = LAMP_R; side_d = LAMP_G; end
        SIDE_EXT: begin value_d = T_EXT;  main_d = LAMP_R; side_d = LAMP_G; end
        SIDE_YEL: begin value_d = T_YEL;  main_d = LAMP_R; side_d = LAMP_Y; end
`ifdef TRAFFIC_WALK_EN
        PED_WALK: begin
          value_d = T_WALK; main_d = LAMP_R; side_d = LAMP_R; walk_d = 1'b1;
        end
`endif
        default:  begin value_d = T_BASE; main_d = LAMP_G; side_d = LAMP_R; end
      endcase
    end else begin
      walk_d = Walk;
    end
  end

`ifdef TRAFFIC_WALK_EN
  // A new request in the same cycle as PED_WALK entry stays pending for the next round.
  always_comb begin
    pend_d = pend_q;
    if (go && state_d == PED_WALK) pend_d = 1'b0;
    if (Walk_Request) pend_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= MAIN_GRN;
      boot_q      <= 1'b1;
      armed_q     <= 1'b0;
      start_timer <= 1'b0;
      Value       <= T_BASE;
      Main_RYG    <= LAMP_G;
      Side_RYG    <= LAMP_R;
    end else begin
      state_q     <= state_d;
      boot_q      <= 1'b0;
      armed_q     <= armed_d;
      start_timer <= start_d;
      Value       <= value_d;
      Main_RYG    <= main_d;
      Side_RYG    <= side_d;
    end
  end

`ifdef TRAFFIC_WALK_EN
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q <= 1'b0;
      Walk   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      Walk   <= walk_d;
    end
  end
`else
  logic unused_walk_d;
  assign unused_walk_d = walk_d;
  assign Walk          = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl with a behavioural Timer (expired Value*8 clks after start).
module tb_traffic_phase_ctrl;

  typedef struct packed {
    logic [3:0] v;
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
  } ent_t;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       expired = 1'b0;
  logic       Sensor = 1'b0;
  logic       Walk_Request = 1'b0;
  logic [3:0] Value;
  logic       start_timer;
  logic [2:0] Main_RYG, Side_RYG;
  logic       Walk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   tmr_cnt = 0;
  logic tmr_exp = 1'b0;
  logic force_exp = 1'b0;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   cyc_q[$];

  traffic_phase_ctrl dut (
    .clk(clk), .Reset_n(Reset_n), .expired(expired), .Sensor(Sensor),
    .Walk_Request(Walk_Request), .Value(Value), .start_timer(start_timer),
    .Main_RYG(Main_RYG), .Side_RYG(Side_RYG), .Walk(Walk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer model, updated away from the active edge
  always @(negedge clk) begin
    if (start_timer) begin
      tmr_cnt = int'(Value) * 8;
      tmr_exp = (Value == 4'd0);
    end else if (tmr_cnt != 0) begin
      tmr_cnt = tmr_cnt - 1;
      tmr_exp = (tmr_cnt == 0);
    end
    expired = tmr_exp | force_exp;
  end

  // Safety: never both roads non-red
  always @(negedge clk) begin
    if (Reset_n) begin
      n_tests++;
      if (Main_RYG != R && Side_RYG != R) begin
        n_fail++;
        $display("FAIL invariant: main=%b side=%b both non-red at cycle %0d", Main_RYG, Side_RYG, cyc);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    Reset_n = 1'b0;
    exp_q.delete(); obs_q.delete(); cyc_q.delete();
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
  endtask

  // Records the outputs seen at each start_timer pulse
  task automatic collect(input int n, input int budget);
    int got = 0;
    int k = 0;
    while (got < n && k < budget) begin
      @(negedge clk);
      k++;
      if (start_timer) begin
        obs_q.push_back(ent_t'({Value, Main_RYG, Side_RYG, Walk}));
        cyc_q.push_back(cyc);
        got++;
      end
    end
    if (got < n) begin
      n_tests++; n_fail++;
      $display("FAIL collect_timeout: got %0d start pulses, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    Sensor = 1'b0; Walk_Request = 1'b0;
    @(negedge clk);
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if ({Value, start_timer, Main_RYG, Side_RYG, Walk} !== {4'd6, 1'b0, G, R, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got v=%0d st=%b m=%b s=%b w=%b, required v=6 st=0 m=001 s=100 w=0",
               Value, start_timer, Main_RYG, Side_RYG, Walk);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({start_timer, Value} !== {1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL first_start: got st=%b v=%0d, required st=1 v=6", start_timer, Value);
    end
  endtask

  task automatic test_rest();
    int bad = 0;
    Sensor = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Main_RYG !== G || Side_RYG !== R) bad++;
      if (start_timer) begin
        obs_q.push_back(ent_t'({Value, Main_RYG, Side_RYG, Walk}));
        cyc_q.push_back(cyc);
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rest_lamps: %0d cycles off main-green, required 0", bad);
    end
    for (int i = 1; i < cyc_q.size(); i++) begin
      n_tests++;
      if (cyc_q[i] - cyc_q[i-1] !== 49) begin
        n_fail++;
        $display("FAIL rest_period[%0d]: got %0d clks, required 49", i, cyc_q[i] - cyc_q[i-1]);
      end
    end
    while (exp_q.size() > 0) begin
      ent_t e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL rest_seq: missing start pulse, required v=%0d", e.v);
      end else begin
        ent_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL rest_seq: got v=%0d m=%b s=%b w=%b, required v=%0d m=%b s=%b w=%b",
                   o.v, o.m, o.s, o.w, e.v, e.m, e.s, e.w);
        end
      end
    end
  endtask

  task automatic test_sensor_cycle();
    Sensor = 1'b1;
    do_reset();
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd2, Y, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, R, G, 1'b0}));
    exp_q.push_back(ent_t'({4'd3, R, G, 1'b0}));
    exp_q.push_back(ent_t'({4'd2, R, Y, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    collect(6, 400);
    while (exp_q.size() > 0) begin
      ent_t e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sensor_seq: missing start pulse, required v=%0d", e.v);
      end else begin
        ent_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL sensor_seq: got v=%0d m=%b s=%b w=%b, required v=%0d m=%b s=%b w=%b",
                   o.v, o.m, o.s, o.w, e.v, e.m, e.s, e.w);
        end
      end
    end
  endtask

  task automatic test_short_sensor();
    Sensor = 1'b1;
    do_reset();
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd2, Y, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, R, G, 1'b0}));
    exp_q.push_back(ent_t'({4'd2, R, Y, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    collect(2, 200);
    Sensor = 1'b0;
    collect(3, 300);
    while (exp_q.size() > 0) begin
      ent_t e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL short_sensor_seq: missing start pulse, required v=%0d", e.v);
      end else begin
        ent_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL short_sensor_seq: got v=%0d m=%b s=%b w=%b, required v=%0d m=%b s=%b w=%b",
                   o.v, o.m, o.s, o.w, e.v, e.m, e.s, e.w);
        end
      end
    end
  endtask

  task automatic test_stale_expired();
    Sensor = 1'b1;
    force_exp = 1'b1;
    do_reset();
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd2, Y, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, R, G, 1'b0}));
    collect(3, 20);
    force_exp = 1'b0;
    for (int i = 1; i < cyc_q.size(); i++) begin
      n_tests++;
      if (cyc_q[i] - cyc_q[i-1] !== 2) begin
        n_fail++;
        $display("FAIL stale_gap[%0d]: got %0d clks between starts, required 2", i, cyc_q[i] - cyc_q[i-1]);
      end
    end
    while (exp_q.size() > 0) begin
      ent_t e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL stale_seq: missing start pulse, required v=%0d", e.v);
      end else begin
        ent_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL stale_seq: got v=%0d m=%b s=%b, required v=%0d m=%b s=%b",
                   o.v, o.m, o.s, e.v, e.m, e.s);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    Sensor = 1'b1;
    do_reset();
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd2, Y, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, R, G, 1'b0}));
    exp_q.push_back(ent_t'({4'd3, R, G, 1'b0}));
    collect(4, 300);
    while (exp_q.size() > 0) begin
      ent_t e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL mid_seq: missing start pulse, required v=%0d", e.v);
      end else begin
        ent_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL mid_seq: got v=%0d m=%b s=%b, required v=%0d m=%b s=%b",
                   o.v, o.m, o.s, e.v, e.m, e.s);
        end
      end
    end
    repeat (3) @(negedge clk);
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if ({Value, start_timer, Main_RYG, Side_RYG, Walk} !== {4'd6, 1'b0, G, R, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0d st=%b m=%b s=%b w=%b, required v=6 st=0 m=001 s=100 w=0",
               Value, start_timer, Main_RYG, Side_RYG, Walk);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({start_timer, Value, Main_RYG, Side_RYG} !== {1'b1, 4'd6, G, R}) begin
      n_fail++;
      $display("FAIL mid_restart: got st=%b v=%0d m=%b s=%b, required st=1 v=6 m=001 s=100",
               start_timer, Value, Main_RYG, Side_RYG);
    end
  endtask

  task automatic test_walk();
    Sensor = 1'b0;
    do_reset();
    collect(1, 10);
    obs_q.delete();
    repeat (3) @(negedge clk);
    Walk_Request = 1'b1;
    @(negedge clk);
    Walk_Request = 1'b0;
`ifdef TRAFFIC_WALK_EN
    exp_q.push_back(ent_t'({4'd2, Y, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, R, G, 1'b0}));
    exp_q.push_back(ent_t'({4'd2, R, Y, 1'b0}));
    exp_q.push_back(ent_t'({4'd5, R, R, 1'b1}));
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    collect(6, 400);
`else
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    exp_q.push_back(ent_t'({4'd6, G, R, 1'b0}));
    collect(2, 200);
`endif
    while (exp_q.size() > 0) begin
      ent_t e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL walk_seq: missing start pulse, required v=%0d", e.v);
      end else begin
        ent_t o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL walk_seq: got v=%0d m=%b s=%b w=%b, required v=%0d m=%b s=%b w=%b",
                   o.v, o.m, o.s, o.w, e.v, e.m, e.s, e.w);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rest();
    test_sensor_cycle();
    test_short_sensor();
    test_stale_expired();
    test_reset_mid();
    test_walk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
